// File: rtl/rect_filler_pkg.sv
// Shared VGA-base constants and types for the rectangle fill engine.
// Holds the default screen geometry used by the pixel memory, the fill FSM
// state encoding, and a width helper for the clipping arithmetic.
package rect_filler_pkg;

  localparam int unsigned H_SIZE      = 640;
  localparam int unsigned V_LINE      = 480;
  localparam int unsigned COLOR_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Width of start + length with one carry bit, so the sum never wraps.
  function automatic int unsigned sum_width(input int unsigned a, input int unsigned b);
    return ((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/rect_filler_if.sv
// Command channel of the rectangle fill engine (valid/ready handshake).
//   cmd_valid / cmd_ready : handshake
//   cmd_x, cmd_y          : top-left corner
//   cmd_w, cmd_h          : size in pixels / lines
//   cmd_color             : fill colour
// master = command source, slave = rect_filler.
interface rect_filler_if
  import rect_filler_pkg::*;
#(
  parameter int unsigned h_size      = H_SIZE,
  parameter int unsigned v_line      = V_LINE,
  parameter int unsigned color_depth = COLOR_DEPTH
) ();

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [$clog2(h_size)-1:0]    cmd_x;
  logic [$clog2(v_line)-1:0]    cmd_y;
  logic [$clog2(h_size+1)-1:0]  cmd_w;
  logic [$clog2(v_line+1)-1:0]  cmd_h;
  logic [color_depth-1:0]       cmd_color;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready
  );

endinterface

// File: rtl/rect_filler_clip_extent.sv
// clip_extent: combinational clipping of one rectangle axis to the screen.
//   start      : first coordinate
//   length     : extent along this axis
//   limit      : screen size along this axis
//   end_coord  : min(start + length, limit) - 1 (last coordinate drawn)
//   degenerate : nothing to draw (zero length or start off-screen)
module clip_extent
  import rect_filler_pkg::*;
#(
  parameter  int unsigned start_w = 10,
  parameter  int unsigned len_w   = 10,
  localparam int unsigned SUM_W   = sum_width(start_w, len_w)
) (
  input  logic [start_w-1:0] start,
  input  logic [len_w-1:0]   length,
  input  logic [SUM_W-1:0]   limit,
  output logic [start_w-1:0] end_coord,
  output logic               degenerate
);

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] clipped;

  always_comb begin
    sum        = SUM_W'(start) + SUM_W'(length);
    clipped    = (sum > limit) ? limit : sum;
    // Only meaningful when not degenerate; clipped >= 1 in that case.
    end_coord  = start_w'(clipped - SUM_W'(1));
    degenerate = (length == '0) || (SUM_W'(start) >= limit);
  end

endmodule

// File: rtl/rect_filler.sv
// rect_filler: fills an axis-aligned rectangle of one colour into the
// frame buffer write port, one pixel per clock in raster order, clipped
// to the screen.
//   clk, reset      : clock, asynchronous active-low reset
//   cmd             : command channel (slave side)
//   hold            : write-port arbiter stall
//   busy            : command in progress (FILL or DONE)
//   done            : one-cycle completion pulse
//   write_en, h_pixel_write, v_pixel_write, color_write : registered write port
module rect_filler
  import rect_filler_pkg::*;
#(
  parameter int unsigned h_size      = H_SIZE,
  parameter int unsigned v_line      = V_LINE,
  parameter int unsigned color_depth = COLOR_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  rect_filler_if.slave               cmd,
  input  logic                       hold,
  output logic                       busy,
  output logic                       done,
  output logic                       write_en,
  output logic [$clog2(h_size)-1:0]  h_pixel_write,
  output logic [$clog2(v_line)-1:0]  v_pixel_write,
  output logic [color_depth-1:0]     color_write
);

  localparam int unsigned XW      = $clog2(h_size);
  localparam int unsigned YW      = $clog2(v_line);
  localparam int unsigned WW      = $clog2(h_size + 1);
  localparam int unsigned HW      = $clog2(v_line + 1);
  localparam int unsigned X_SUM_W = sum_width(XW, WW);
  localparam int unsigned Y_SUM_W = sum_width(YW, HW);

  localparam logic [X_SUM_W-1:0] X_LIMIT = X_SUM_W'(h_size);
  localparam logic [Y_SUM_W-1:0] Y_LIMIT = Y_SUM_W'(v_line);

  fill_state_t            state;
  logic [XW-1:0]          x0;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [XW-1:0]          x_end;
  logic [YW-1:0]          y_end;
  logic [color_depth-1:0] fill_color;

  logic [XW-1:0] x_end_c;
  logic [YW-1:0] y_end_c;
  logic          x_degen;
  logic          y_degen;
  logic          cmd_ready_int;

  clip_extent #(.start_w(XW), .len_w(WW)) u_clip_x (
    .start      (cmd.cmd_x),
    .length     (cmd.cmd_w),
    .limit      (X_LIMIT),
    .end_coord  (x_end_c),
    .degenerate (x_degen)
  );

  clip_extent #(.start_w(YW), .len_w(HW)) u_clip_y (
    .start      (cmd.cmd_y),
    .length     (cmd.cmd_h),
    .limit      (Y_LIMIT),
    .end_coord  (y_end_c),
    .degenerate (y_degen)
  );

  // The cycle after DONE still carries the registered done pulse; holding
  // off the next command for that cycle gives the two-cycle turnaround.
  assign cmd_ready_int = (state == IDLE) && !done;
  assign cmd.cmd_ready = cmd_ready_int;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      x0            <= '0;
      x             <= '0;
      y             <= '0;
      x_end         <= '0;
      y_end         <= '0;
      fill_color    <= '0;
      write_en      <= 1'b0;
      done          <= 1'b0;
      h_pixel_write <= '0;
      v_pixel_write <= '0;
      color_write   <= '0;
    end else begin
      write_en <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd.cmd_valid && cmd_ready_int) begin
            x0         <= cmd.cmd_x;
            x          <= cmd.cmd_x;
            y          <= cmd.cmd_y;
            x_end      <= x_end_c;
            y_end      <= y_end_c;
            fill_color <= cmd.cmd_color;
            state      <= (x_degen || y_degen) ? DONE : FILL;
          end
        end
        FILL: begin
          if (!hold) begin
            write_en      <= 1'b1;
            h_pixel_write <= x;
            v_pixel_write <= y;
            color_write   <= fill_color;
            if (x < x_end) begin
              x <= x + XW'(1);
            end else if (y < y_end) begin
              x <= x0;
              y <= y + YW'(1);
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_filler.sv
// Scoreboard bench for rect_filler: the driver pushes expected writes and
// the done pulse (with their cycle numbers) into a queue; an independent
// monitor pops and compares whenever the DUT presents a write or done.
module tb_rect_filler;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int CD = 8;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);
  localparam int WW = $clog2(H + 1);
  localparam int HW = $clog2(V + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          hold = 1'b0;
  logic          busy;
  logic          done;
  logic          write_en;
  logic [XW-1:0] h_pixel_write;
  logic [YW-1:0] v_pixel_write;
  logic [CD-1:0] color_write;

  rect_filler_if #(.h_size(H), .v_line(V), .color_depth(CD)) cmd_if ();

  rect_filler #(.h_size(H), .v_line(V), .color_depth(CD)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (cmd_if.slave),
    .hold          (hold),
    .busy          (busy),
    .done          (done),
    .write_en      (write_en),
    .h_pixel_write (h_pixel_write),
    .v_pixel_write (v_pixel_write),
    .color_write   (color_write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int x;
    int y;
    int color;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write or done pulse must match the queue head, including its cycle.
  always @(negedge clk) begin
    if (mon_en && reset && (write_en || done)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual we=%0d done=%0d x=%0d y=%0d required none (cycle %0d)",
                 write_en, done, h_pixel_write, v_pixel_write, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("out_kind_is_done", int'(done), int'(mon_e.is_done));
        check("out_cycle", cyc, mon_e.at);
        if (!mon_e.is_done) begin
          check("wr_x", int'(h_pixel_write), mon_e.x);
          check("wr_y", int'(v_pixel_write), mon_e.y);
          check("wr_color", int'(color_write), mon_e.color);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_write_en"}, int'(write_en), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_cmd_ready"}, int'(cmd_if.cmd_ready), 1);
    check({tag, "_h"}, int'(h_pixel_write), 0);
    check({tag, "_v"}, int'(v_pixel_write), 0);
    check({tag, "_color"}, int'(color_write), 0);
  endtask

  // Issue one command. done_off is the hand-computed cycle offset of done
  // from the accept edge; hold is raised for hold_len cycles starting hold_at
  // cycles after acceptance. track=0 issues without expectations.
  task automatic issue(input int x, input int y, input int w, input int h, input int color,
                       input int hold_at, input int hold_len, input int done_off, input bit track);
    int n;
    int t;
    int xe;
    int ye;
    int budget;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_x     = XW'(x);
    cmd_if.cmd_y     = YW'(y);
    cmd_if.cmd_w     = WW'(w);
    cmd_if.cmd_h     = HW'(h);
    cmd_if.cmd_color = CD'(color);
    budget = 0;
    while (!cmd_if.cmd_ready) begin
      @(negedge clk);
      budget++;
      if (budget > 50) begin
        check("accept_timeout", 0, 1);
        cmd_if.cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    n = cyc;
    cmd_if.cmd_valid = 1'b0;
    if (!track) return;
    check("busy_after_accept", int'(busy), 1);

    xe = (((x + w) < H) ? (x + w) : H) - 1;
    ye = (((y + h) < V) ? (y + h) : V) - 1;
    t  = n;
    if (!(w == 0 || h == 0 || x >= H || y >= V)) begin
      for (int yy = y; yy <= ye; yy++) begin
        for (int xx = x; xx <= xe; xx++) begin
          while (hold_len > 0 && t >= n + hold_at && t < n + hold_at + hold_len) t++;
          sb.push_back('{is_done: 1'b0, x: xx, y: yy, color: color, at: t + 1});
          t++;
        end
      end
    end
    sb.push_back('{is_done: 1'b1, x: 0, y: 0, color: 0, at: n + done_off});

    if (hold_len > 0) begin
      repeat (hold_at) @(posedge clk);
      #1;
      hold = 1'b1;
      repeat (hold_len) @(posedge clk);
      #1;
      hold = 1'b0;
    end

    repeat ((n + done_off) - cyc) @(posedge clk);
    @(negedge clk);
    check("ready_in_done_cycle", int'(cmd_if.cmd_ready), 0);
    @(negedge clk);
    check("ready_after_done", int'(cmd_if.cmd_ready), 1);
    check("busy_after_done", int'(busy), 0);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_x     = '0;
    cmd_if.cmd_y     = '0;
    cmd_if.cmd_w     = '0;
    cmd_if.cmd_h     = '0;
    cmd_if.cmd_color = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    // x, y, w, h, colour, hold_at, hold_len, done_off, track
    issue(10, 20, 3, 2, 8'hA5, 0, 0, 7, 1'b1);
    issue(638, 479, 5, 4, 8'h5A, 0, 0, 3, 1'b1);
    issue(100, 100, 0, 5, 8'h01, 0, 0, 1, 1'b1);
    issue(640, 10, 3, 2, 8'h02, 0, 0, 1, 1'b1);
    issue(5, 5, 4, 0, 8'h03, 0, 0, 1, 1'b1);
    issue(5, 480, 4, 2, 8'h04, 0, 0, 1, 1'b1);
    issue(630, 0, 20, 1, 8'hC3, 0, 0, 11, 1'b1);

    // Reset pulse while idle with non-zero output registers.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("idle_reset");
    @(negedge clk);
    reset = 1'b1;

    issue(0, 0, 4, 1, 8'h3C, 2, 2, 7, 1'b1);

    // Reset in the middle of a large fill: writes stop at once, no done.
    mon_en = 1'b0;
    issue(0, 0, 100, 100, 8'h77, 0, 0, 0, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    check("fill_running", int'(write_en), 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("fill_reset");
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(posedge clk);
    check("no_done_after_abort", sb.size(), 0);

    issue(5, 7, 1, 1, 8'h11, 0, 0, 2, 1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
